// File: rtl/spi_rx_pkg.sv
// Shared types and helpers for the multi-lane SPI receive path.
// lane_mode_e encodes the lane count; 2'b11 is reserved and behaves as SINGLE.
package spi_rx_pkg;

    typedef enum logic [1:0] {
        SINGLE = 2'b00,
        DUAL   = 2'b01,
        QUAD   = 2'b10
    } lane_mode_e;

    function automatic logic [2:0] lanes_of(input logic [1:0] mode);
        case (mode)
            DUAL:    return 3'd2;
            QUAD:    return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    // Edges needed to move 'bits' bits; a zero length still moves one bit.
    function automatic logic [31:0] ceil_edges(input logic [31:0] bits, input logic [1:0] mode);
        logic [31:0] b;
        b = (bits == 32'd0) ? 32'd1 : bits;
        case (mode)
            DUAL:    b = 32'((33'(b) + 33'd1) >> 1);
            QUAD:    b = 32'((33'(b) + 33'd3) >> 2);
            default: b = b;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_rx_lane_shifter.sv
// Lane-aware shift register and bit counter; flags a finished word and presents
// it right-justified (zero upper bits) in the same cycle as the completing edge.
module spi_rx_lane_shifter
    import spi_rx_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              shift,
    input  logic              last,
    input  logic              lsb_first,
    input  logic [1:0]        mode,
    input  logic [3:0]        sdi,
    output logic              word_done,
    output logic [DATA_W-1:0] word
);

    localparam int BW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nxt;
    logic [BW-1:0]     bit_cnt;
    logic [BW-1:0]     bit_nxt;

    always_comb begin
        shreg_nxt = shreg;
        case (mode)
            DUAL:    shreg_nxt = lsb_first ? {sdi[1:0], shreg[DATA_W-1:2]}
                                           : {shreg[DATA_W-3:0], sdi[1:0]};
            QUAD:    shreg_nxt = lsb_first ? {sdi[3:0], shreg[DATA_W-1:4]}
                                           : {shreg[DATA_W-5:0], sdi[3:0]};
            default: shreg_nxt = lsb_first ? {sdi[0], shreg[DATA_W-1:1]}
                                           : {shreg[DATA_W-2:0], sdi[0]};
        endcase
    end

    assign bit_nxt   = bit_cnt + BW'(lanes_of(mode));
    assign word_done = shift & (last | (bit_nxt == BW'(DATA_W)));

    // LSB-first words fill from the top, so a short word must be slid down.
    always_comb begin
        word = shreg_nxt;
        if (lsb_first) begin
            word = shreg_nxt >> (DATA_W - int'(bit_nxt));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (clr || word_done) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (shift) begin
            shreg   <= shreg_nxt;
            bit_cnt <= bit_nxt;
        end
    end

endmodule

// File: rtl/spi_master_rx_mlane.sv
// Multi-lane SPI master receiver: edge/transfer counting, output register, overflow.
// Optional LSB-first reception is compiled in with `define SPI_RX_LSB_FIRST_EN.
module spi_master_rx_mlane
    import spi_rx_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int CNT_W    = 16,
    parameter int RST_BITS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              rx_edge,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  counter_in,
    input  logic              counter_in_upd,
`ifdef SPI_RX_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    input  logic [3:0]        sdi,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              rx_done,
    output logic              overflow,
    input  logic              clr_overflow
);

    lane_mode_e        mode_q;
    logic [CNT_W-1:0]  edge_cnt;
    logic [CNT_W-1:0]  target_edges;
    logic              lsb_q;
    logic              shift;
    logic              last_edge;
    logic              word_done;
    logic [DATA_W-1:0] word;

    // A restart in the same cycle as a sample strobe swallows that strobe.
    assign shift     = en & rx_edge & ~counter_in_upd;
    assign last_edge = (edge_cnt == target_edges - CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt     <= '0;
            target_edges <= CNT_W'(RST_BITS);
            mode_q       <= SINGLE;
        end else if (counter_in_upd) begin
            edge_cnt     <= '0;
            target_edges <= CNT_W'(ceil_edges(32'(counter_in), mode));
            mode_q       <= (mode == 2'b11) ? SINGLE : lane_mode_e'(mode);
        end else if (shift) begin
            edge_cnt     <= last_edge ? '0 : edge_cnt + CNT_W'(1);
        end
    end

`ifdef SPI_RX_LSB_FIRST_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lsb_q <= 1'b0;
        end else if (counter_in_upd) begin
            lsb_q <= lsb_first;
        end
    end
`else
    assign lsb_q = 1'b0;
`endif

    spi_rx_lane_shifter #(
        .DATA_W (DATA_W)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .clr       (counter_in_upd),
        .shift     (shift),
        .last      (last_edge),
        .lsb_first (lsb_q),
        .mode      (mode_q),
        .sdi       (sdi),
        .word_done (word_done),
        .word      (word)
    );

    // Handshake: a word transfers on any clock where data_valid & data_ready;
    // data is held stable while data_valid is high and data_ready is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data       <= '0;
            data_valid <= 1'b0;
            rx_done    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            rx_done <= word_done & last_edge;
            if (word_done && (!data_valid || data_ready)) begin
                data       <= word;
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
            if (clr_overflow) begin
                overflow <= 1'b0;
            end else if (word_done && data_valid && !data_ready) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/spi_master_rx_mlane.md
Name: spi_master_rx_mlane

Overview:
- Parametrised SPI master receive shifter; successor to the fixed 32-bit single/quad receiver.
- Supports single, dual or quad lane mode, a configurable word width and transfer length, and partial final words.
- Adds a valid/ready output register with sticky overflow detection.
- Sits between the SPI clock-gen/controller (supplies rx_edge, en, transfer length) and the RX FIFO.

Parameters:
- DATA_W, 32, output word width in bits; must be a multiple of 4, min 8.
- CNT_W, 16, width of the transfer-length counters.
- RST_BITS, 8, reset value of the target transfer length in bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  receive enable; rx_edge ignored when low.
- rx_edge  in  1  single-cycle sample strobe from the clock generator.
- mode  in  2  lane mode (spi_rx_pkg::lane_mode_e), latched on counter_in_upd.
- counter_in  in  CNT_W  transfer length in bits.
- counter_in_upd  in  1  load counter_in and mode; restarts the transfer.
- sdi  in  4  serial data lanes; sdi[0] is the single-mode lane.
- data  out  DATA_W  received word.
- data_valid  out  1  data holds an unconsumed word.
- data_ready  in  1  consumer accepts the word.
- rx_done  out  1  one-cycle pulse at end of transfer.
- overflow  out  1  sticky: a word was dropped.
- clr_overflow  in  1  clears overflow.

Behaviour:
- Reset: data=0, data_valid=0, rx_done=0, overflow=0, shift register=0, edge counter=0, bit counter=0, target=RST_BITS, mode_q=SINGLE.
- Lanes L: 1 (SINGLE=00), 2 (DUAL=01), 4 (QUAD=10). Reserved mode 11 is treated as SINGLE.
- Target edges = ceil(counter_in/L), computed at counter_in_upd.
- counter_in=0 is treated as 1 bit.
- counter_in_upd clears the edge counter, the bit counter and the shift register; the word in the output register is kept.
- Counting happens on en & rx_edge only:
  - MSB-first shift: shreg = {shreg[DATA_W-L-1:0], sdi[L-1:0]}, with sdi[L-1] most significant.
  - bit_cnt += L and edge_cnt += 1.
- Word completion: bit_cnt reaches DATA_W, or the last edge of the transfer arrives. A partial word is right-justified with zero upper bits. bit_cnt and shreg then clear.
- Output register, loaded the clock after the completing edge (latency 1 cycle):
  - Free, or freed this cycle (data_valid & data_ready): load data and set data_valid=1.
  - Otherwise: drop the new word, hold the old one, and set overflow=1.
- data_valid drops the cycle after a handshake unless a new word loads in the same cycle.
- data must stay stable while data_valid=1 and data_ready=0.
- rx_done: registered pulse in the same cycle the final word would load, even if that word is dropped.
- After the last edge, edge_cnt wraps to 0 and the next transfer of the same length starts without another counter_in_upd.
- clr_overflow has priority over a same-cycle overflow set.
- counter_in_upd in the same cycle as rx_edge: the update wins and the edge is discarded.
- Reset mid-transfer discards the partial word; no rx_done is generated.

Optional Feature:
- SPI_RX_LSB_FIRST_EN defined:
  - Adds input lsb_first (1 bit), latched on counter_in_upd.
  - When set, bits shift in from the top: shreg = {sdi[L-1:0], shreg[DATA_W-1:L]}, with sdi[0] the least significant of the group.
  - A partial word is right-aligned by shifting down (DATA_W - bit_cnt) at completion.
- Not defined: no port; MSB-first only.

Decomposition:
- spi_rx_pkg holds:
  - lane_mode_e {SINGLE=2'b00, DUAL=2'b01, QUAD=2'b10}.
  - Function lanes_of(mode) returning 1/2/4.
  - Function ceil_edges(bits, mode).
- Sub-module spi_rx_lane_shifter (shift register, bit counter, partial-word alignment; params DATA_W). The top holds the counters, output register and overflow.

Test Plan:
- SINGLE, counter_in=32, 32 edges carrying 0xA5A5F00F MSB-first -> data=0xA5A5F00F, data_valid 1 cycle after edge 32, rx_done pulses the same cycle.
- QUAD, counter_in=64, 16 edges with nibbles 1..F,0 -> words 0x12345678 (after edge 8) and 0x9ABCDEF0 (after edge 16), then rx_done.
- DUAL, counter_in=12, 6 edges with pairs 10,10,10,11,11,00 -> data=0x00000ABC, rx_done, edge counter wraps to 0.
- data_ready=0, two SINGLE 32-bit words -> data holds the first word, overflow=1; clr_overflow -> 0. data_ready pulse with a simultaneous completion -> new word loads, no overflow.
- en=0 with 10 rx_edges -> no counter change, no data_valid. counter_in_upd on the same cycle as rx_edge -> edge discarded.
- Reset asserted after edge 10 of 32 -> all outputs 0 immediately, target=8. Next 8 edges of 0xC3 -> data=0x000000C3 and rx_done.
